// File: rtl/parity_frame_checker.sv
// parity_frame_checker: bit-serial receiver. It shifts in DATA_W data bits
// (MSB first) and then one parity bit. Each result is presented as a
// parallel word, a parity value and an error flag.
// Optional feature macro: PARITY_ODD_EN selects odd parity (default is even).
module parity_frame_checker #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              par_out,
  output logic              par_err,
  output logic              done
);

`ifdef PARITY_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, RECV, PAR, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shift;
  logic              acc;
  logic [CW-1:0]     cnt;
  logic              xfer;

  // The handshake decodes from the state register only, so every output
  // is a function of flops and never of this cycle's inputs.
  assign xfer = bit_valid & bit_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and Moore outputs
  always_comb begin
    state_nxt = state;
    bit_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RECV;
      end
      RECV: begin
        bit_ready = 1'b1;
        if (xfer && cnt == CW'(DATA_W - 1)) state_nxt = PAR;
      end
      PAR: begin
        bit_ready = 1'b1;
        if (xfer) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: shift/fold the frame. Results update only on the parity
  // transfer, so the previous frame's result stays visible during a new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift    <= '0;
      acc      <= 1'b0;
      cnt      <= '0;
      data_out <= '0;
      par_out  <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          shift <= '0;
          acc   <= 1'b0;
          cnt   <= '0;
        end
        RECV: if (xfer) begin
          shift <= {shift[DATA_W-2:0], bit_in};
          acc   <= acc ^ bit_in;
          cnt   <= cnt + CW'(1);
        end
        PAR: if (xfer) begin
          data_out <= shift;
          par_out  <= acc ^ ODD;
          par_err  <= bit_in ^ acc ^ ODD;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker (DATA_W=8). The parity expectations
// are hand-computed even-parity values, flipped when PARITY_ODD_EN is defined.
module tb_parity_frame_checker;

`ifdef PARITY_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready, busy, par_out, par_err, done;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;
  int lat;

  parity_frame_checker #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .busy(busy),
    .data_out(data_out), .par_out(par_out), .par_err(par_err), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a frame and send it. The task returns in the cycle where done is
  // seen, or after a bounded wait. It reports the cycle count from the start
  // edge to that cycle.
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input int stall_mid, input int stall_par,
                            input bit start_in_recv, output int n);
    n = 0;
    start = 1'b1;
    tick(); n++;
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bit_in    = d[i];
      bit_valid = 1'b1;
      start     = start_in_recv && (i == 5);
      tick(); n++;
      start = 1'b0;
      if (i == 4) begin
        for (int s = 0; s < stall_mid; s++) begin
          bit_valid = 1'b0;
          chk("ready_in_stall", bit_ready, 1);
          tick(); n++;
        end
      end
    end
    for (int s = 0; s < stall_par; s++) begin
      bit_valid = 1'b0;
      chk("ready_before_par", bit_ready, 1);
      tick(); n++;
    end
    bit_in    = p;
    bit_valid = 1'b1;
    tick(); n++;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    for (int w = 0; w < 5 && !done; w++) begin
      tick(); n++;
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", bit_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_data", data_out, 0);
    chk("rst_par", par_out, 0);
    chk("rst_err", par_err, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Clean frame A5 (four ones), parity 0
    send_frame(8'hA5, 1'b0, 0, 0, 0, lat);
    chk("a5_lat", lat, 10);
    chk("a5_done", done, 1);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_par", par_out, 1'b0 ^ ODD);
    chk("a5_err", par_err, 1'b0 ^ ODD);
    tick();
    chk("a5_done_low", done, 0);
    chk("a5_idle", busy, 0);

    // Frame 01 (one 1), parity 0: the even build flags an error
    send_frame(8'h01, 1'b0, 0, 0, 0, lat);
    chk("01_lat", lat, 10);
    chk("01_data", data_out, 8'h01);
    chk("01_par", par_out, 1'b1 ^ ODD);
    chk("01_err", par_err, 1'b1 ^ ODD);
    tick();
    chk("01_pulse", done, 0);
    tick();
    chk("01_pulse2", done, 0);

    // The result is held while the next frame is being received
    start = 1'b1; tick(); start = 1'b0;
    chk("hold_busy", busy, 1);
    chk("hold_ready", bit_ready, 1);
    chk("hold_data", data_out, 8'h01);
    chk("hold_err", par_err, 1'b1 ^ ODD);
    // Abandon this frame with a reset; outputs clear asynchronously
    #2 rst = 1'b1;
    #1;
    chk("rst_async_data", data_out, 0);
    chk("rst_async_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();

    // Stalls: 3 after bit 4, 2 before parity
    send_frame(8'hF0, 1'b0, 3, 2, 0, lat);
    chk("f0_lat", lat, 15);
    chk("f0_done", done, 1);
    chk("f0_data", data_out, 8'hF0);
    chk("f0_err", par_err, 1'b0 ^ ODD);
    tick();

    // start pulse during RECV is ignored, then start in DONE is ignored
    send_frame(8'h3C, 1'b0, 0, 0, 1, lat);
    chk("ign_lat", lat, 10);
    chk("ign_data", data_out, 8'h3C);
    start = 1'b1; tick(); start = 1'b0;
    chk("ign_done_start_busy", busy, 0);
    chk("ign_done_low", done, 0);
    tick();
    chk("ign_still_idle", busy, 0);
    chk("ign_no_ready", bit_ready, 0);
    tick();
    chk("ign_no_done", done, 0);

    // Reset mid-RECV for 2 cycles, then a clean frame
    start = 1'b1; tick(); start = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1;
    tick(); tick(); tick();
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_ready", bit_ready, 0);
    chk("mid_done", done, 0);
    chk("mid_data", data_out, 0);
    chk("mid_par", par_out, 0);
    chk("mid_err", par_err, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("mid_idle", busy, 0);
    send_frame(8'h3C, 1'b0, 0, 0, 0, lat);
    chk("post_lat", lat, 10);
    chk("post_data", data_out, 8'h3C);
    chk("post_err", par_err, 1'b0 ^ ODD);
    tick();

`ifdef PARITY_ODD_EN
    send_frame(8'hA5, 1'b1, 0, 0, 0, lat);
    chk("odd_a5p1_par", par_out, 1);
    chk("odd_a5p1_err", par_err, 0);
    tick();
    send_frame(8'hA5, 1'b0, 0, 0, 0, lat);
    chk("odd_a5p0_err", par_err, 1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Bit-serial receive stage that consumes a stream of single-bit data, folds it through a running XOR, and checks it against a trailing parity bit. It sits downstream of the team's XOR/parity primitives and serial bit sources. It presents a parallel word plus a parity-error flag to the next stage. A valid/ready handshake paces it on the input side, and a one-cycle done pulse marks each result on the output side.

## Interface
- DATA_W, 8, number of data bits per frame (≥2); a frame is DATA_W data bits, MSB first, then 1 parity bit
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to begin a frame; sampled only in IDLE
- bit_in  in  1  serial data/parity bit
- bit_valid  in  1  bit_in is valid this cycle
- bit_ready  out  1  block accepts a bit this cycle; a bit transfers on bit_valid & bit_ready
- busy  out  1  high in any state other than IDLE
- data_out  out  DATA_W  last received data word, held until the next frame completes
- par_out  out  1  computed parity of data_out, including the configured sense
- par_err  out  1  received parity bit differs from par_out; held with data_out
- done  out  1  one-cycle pulse when data_out/par_out/par_err update

## Operation
- States: IDLE, RECV, PAR, DONE; 2-bit state register.
- IDLE: bit_ready=0, busy=0. When start=1, clear the shift register, running XOR and bit counter, then go to RECV.
- RECV: bit_ready=1. On each transfer:
  - shift = {shift[DATA_W-2:0], bit_in}
  - acc ^= bit_in
  - cnt++
  - when the transfer brings cnt to DATA_W, go to PAR
- PAR: bit_ready=1. On a transfer:
  - data_out ← shift
  - par_out ← acc ^ ODD
  - par_err ← bit_in ^ acc ^ ODD
  - go to DONE
- DONE: done=1, bit_ready=0. Unconditionally return to IDLE next cycle.
- Cycles with bit_valid=0 in RECV/PAR are stalls: no state change.
- start while busy is ignored, with no queuing.
- start asserted in the DONE cycle is ignored; start must be seen in IDLE.
- Counter width is $clog2(DATA_W+1); it never wraps within a frame.
- data_out, par_out and par_err change only on the PAR transfer. They keep their previous frame's values during a new frame.

## Timing
- Reset values: state=IDLE; bit_ready=0, busy=0, done=0, par_out=0, par_err=0; data_out, shift, acc and cnt all 0.
- start sampled at edge N puts the block in RECV from cycle N+1.
- With bit_valid held high, the first data bit transfers in cycle N+1 and the parity bit in cycle N+DATA_W+1.
- done is high in cycle N+DATA_W+2, and outputs are valid in that same cycle.
- Minimum frame-to-frame period is DATA_W+3 cycles (start, DATA_W+1 bits, DONE).
- rst asserted mid-frame forces all registers to their reset values immediately. The partial frame is discarded and no done pulse is produced.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro `PARITY_ODD_EN` is defined: ODD=1, so the frame expects odd parity. par_out = ~^data, and par_err=1 when the total ones count including the parity bit is even.
- Macro `PARITY_ODD_EN` is undefined (default): ODD=0, even parity. par_out = ^data, and par_err=1 when the total ones count is odd.

## Test plan
- Reset during operation: assert rst for 2 cycles mid-RECV → all outputs 0 and state IDLE immediately. A following clean frame of 8'h3C with parity 0 → data_out=8'h3C, par_err=0.
- Clean frame, even build, DATA_W=8: start, bits of 8'hA5 then parity 0 with valid held high → done at start+10 cycles, data_out=8'hA5, par_out=0, par_err=0.
- Error detect, even build: bits of 8'h01 then parity 0 → par_out=1, par_err=1, done a single one-cycle pulse.
- Stalls: 8'hF0 with bit_valid low for 3 cycles after bit 4 and 2 cycles before parity 0 → done at start+15, data_out=8'hF0, par_err=0. Confirm bit_ready stays high through the stalls.
- Ignored start: pulse start during RECV and during DONE → no restart, exactly one done pulse per frame, busy low only in IDLE.
- Odd build (`PARITY_ODD_EN`): 8'hA5 with parity 1 → par_out=1, par_err=0. 8'hA5 with parity 0 → par_err=1.
